caprom_window_v2: RTL and testbench

- Next-generation CSR-visible discovery ROM: exposes NUM_WIN independently enabled table windows (discovery, topology, limits, feature bitmaps, ...) on one csr_if slave.
- Table bytes live in an external synchronous ROM with fixed read latency ROM_LAT; the block fetches, merges, faults and responds.
- Supports unaligned reads spanning two ROM words, and a lockable control register that gates window visibility.
- Sits behind the CSR fabric next to the other capability blocks.

---
 rtl/caprom_window_v2.sv | 205 ++++++++++++++++++++
 tb/tb_caprom_window_v2.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/caprom_window_v2.sv
// rtl/caprom_window_v2.sv - CSR-visible discovery ROM with enable-gated table windows
// Fetches one or two ROM words per read, merges unaligned bytes, and owns a lockable control register.
module caprom_window_v2 #(
  parameter int              ADDR_W          = 32,
  parameter int              DATA_W          = 32,
  parameter int              NUM_WIN         = 4,
  parameter int              WIN_BYTES       = 256,
  parameter int              WIN_STRIDE      = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter int              ROM_LAT         = 1,
  parameter int              ALLOW_UNALIGNED = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [ADDR_W-1:0]                     req_addr,
  input  logic                                  req_write,
  input  logic [DATA_W-1:0]                     req_wdata,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [DATA_W-1:0]                     rsp_rdata,
  output logic                                  rsp_fault,
  output logic                                  rsp_side_effect,
  output logic                                  rom_rd_en,
  output logic [$clog2(NUM_WIN*WIN_BYTES)-1:0]  rom_addr,
  input  logic [DATA_W-1:0]                     rom_rdata,
  output logic [NUM_WIN-1:0]                    win_en,
  output logic                                  locked
);

  localparam int RA       = $clog2(NUM_WIN*WIN_BYTES);
  localparam int DB       = DATA_W / 8;
  localparam int AW1      = ADDR_W + 1;
  localparam int WW       = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam int CW       = $clog2(ROM_LAT + 1);
  localparam int LOCK_BIT = (DATA_W > 31) ? 31 : DATA_W - 1;

  localparam logic [AW1-1:0] BASE_X   = {1'b0, BASE_ADDR};
  localparam logic [AW1-1:0] STRIDE_X = AW1'(WIN_STRIDE);
  localparam logic [AW1-1:0] WINB_X   = AW1'(WIN_BYTES);
  localparam logic [AW1-1:0] DB_X     = AW1'(DB);
  localparam logic [AW1-1:0] CTRL_X   = BASE_X + AW1'(NUM_WIN * WIN_STRIDE);
  localparam bit             CTRL_UNAL = (CTRL_X % DB_X) != '0;
  localparam bit             NO_UNAL   = (ALLOW_UNALIGNED == 0);

  typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, RESP} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic                span_q;
  logic [3:0]          sh_q;
  logic [RA-1:0]       a1_q;
  logic [DATA_W-1:0]   word0_q;

  logic [AW1-1:0]      addr_x, off, win_x, woff, sh_x, a0_x;
  logic [WW-1:0]       win_idx;
  logic                below, above, is_ctrl, unal, overrun, win_on, fault;
  logic                rd_fire, lat_hit;
  logic [RA-1:0]       rd_addr;
  logic [DATA_W-1:0]   ctrl_val, merged;
  logic [2*DATA_W-1:0] shifted;
  logic                unused_bits;

  // Offsets are computed one bit wider than the bus so addresses near the top never wrap.
  always_comb begin
    addr_x  = {1'b0, req_addr};
    off     = addr_x - BASE_X;
    win_x   = off / STRIDE_X;
    woff    = off % STRIDE_X;
    sh_x    = woff % DB_X;
    a0_x    = win_x * WINB_X + woff - sh_x;
    win_idx = win_x[WW-1:0];
    below   = addr_x < BASE_X;
    above   = addr_x > CTRL_X;
    is_ctrl = addr_x == CTRL_X;
    unal    = sh_x != '0;
    overrun = (woff + DB_X) > WINB_X;
    win_on  = win_en[win_idx];
    if (below || above)
      fault = 1'b1;
    else if (is_ctrl)
      fault = CTRL_UNAL || (req_write && locked);
    else
      fault = req_write || overrun || !win_on || (unal && NO_UNAL);
  end

  always_comb begin
    ctrl_val              = '0;
    ctrl_val[NUM_WIN-1:0] = win_en;
    ctrl_val[LOCK_BIT]    = locked;
  end

  // Response byte b is window byte woff+b: tail of word 0, then head of word 1.
  assign shifted     = {rom_rdata, word0_q} >> {sh_q, 3'b000};
  assign merged      = shifted[DATA_W-1:0];
  assign lat_hit     = cnt_q == CW'(ROM_LAT);
  assign req_ready   = (state_q == IDLE);
  assign unused_bits = ^{req_wdata, win_x, shifted};

  always_comb begin
    state_d = state_q;
    rd_fire = 1'b0;
    rd_addr = a1_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (fault || is_ctrl) begin
            state_d = RESP;
          end else begin
            state_d = FETCH0;
            rd_fire = 1'b1;
            rd_addr = RA'(a0_x);
          end
        end
      end
      FETCH0: begin
        if (lat_hit) begin
          if (span_q) begin
            state_d = FETCH1;
            rd_fire = 1'b1;
          end else begin
            state_d = RESP;
          end
        end
      end
      FETCH1: if (lat_hit) state_d = RESP;
      RESP:   if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_fault       <= 1'b0;
      rsp_side_effect <= 1'b0;
      rom_rd_en       <= 1'b0;
      rom_addr        <= '0;
      win_en          <= '1;
      locked          <= 1'b0;
      cnt_q           <= '0;
      span_q          <= 1'b0;
      sh_q            <= '0;
      a1_q            <= '0;
      word0_q         <= '0;
    end else begin
      rom_rd_en <= rd_fire;
      if (rd_fire) begin
        rom_addr <= rd_addr;
        cnt_q    <= '0;
      end else if (!lat_hit) begin
        cnt_q <= cnt_q + CW'(1);
      end
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            span_q <= unal;
            sh_q   <= 4'(sh_x);
            a1_q   <= RA'(a0_x + DB_X);
            if (fault || is_ctrl) begin
              rsp_valid       <= 1'b1;
              rsp_fault       <= fault;
              rsp_side_effect <= !fault && req_write;
              rsp_rdata       <= (!fault && !req_write) ? ctrl_val : '0;
              if (!fault && req_write) begin
                win_en <= req_wdata[NUM_WIN-1:0];
                locked <= req_wdata[LOCK_BIT];
              end
            end
          end
        end
        FETCH0: begin
          if (lat_hit) begin
            if (span_q) begin
              word0_q <= rom_rdata;
            end else begin
              rsp_valid       <= 1'b1;
              rsp_rdata       <= rom_rdata;
              rsp_fault       <= 1'b0;
              rsp_side_effect <= 1'b0;
            end
          end
        end
        FETCH1: begin
          if (lat_hit) begin
            rsp_valid       <= 1'b1;
            rsp_rdata       <= merged;
            rsp_fault       <= 1'b0;
            rsp_side_effect <= 1'b0;
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_caprom_window_v2.sv
// tb/tb_caprom_window_v2.sv - directed self-checking bench for caprom_window_v2
// ROM byte n holds n[7:0]; windows start at 0x1000, control register at 0x1400.
module tb_caprom_window_v2;

  localparam int RA = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_write;
  logic [31:0]       req_addr, req_wdata;
  logic              rsp_valid, rsp_ready, rsp_fault, rsp_side_effect;
  logic [31:0]       rsp_rdata;
  logic              rom_rd_en;
  logic [RA-1:0]     rom_addr;
  logic [31:0]       rom_rdata;
  logic [3:0]        win_en;
  logic              locked;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  caprom_window_v2 #(
    .ROM_LAT  (2),
    .BASE_ADDR(32'h0000_1000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_write      (req_write),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_fault      (rsp_fault),
    .rsp_side_effect(rsp_side_effect),
    .rom_rd_en      (rom_rd_en),
    .rom_addr       (rom_addr),
    .rom_rdata      (rom_rdata),
    .win_en         (win_en),
    .locked         (locked)
  );

  // Two-stage ROM pipeline: the word for an address strobed in cycle C is on rom_rdata in C+2.
  logic [RA-1:0] p0 = '0, p1 = '0;
  always @(posedge clk) begin
    p0 <= rom_addr;
    p1 <= p0;
  end
  assign rom_rdata = {8'(p1 + 3), 8'(p1 + 2), 8'(p1 + 1), 8'(p1)};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic xact(input string tag, input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic [31:0] e_rd, input logic e_flt, input logic e_se, input int e_lat,
                      input int e_nrd, input logic [RA-1:0] e_ra0, input logic [RA-1:0] e_ra1);
    int lat, nrd;
    logic [RA-1:0] ra0, ra1;
    check({tag, ".req_ready"}, req_ready, 1'b1);
    req_addr = a; req_write = w; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; nrd = 0; ra0 = '0; ra1 = '0;
    while (!rsp_valid && lat < 40) begin
      if (rom_rd_en) begin
        if (nrd == 0) ra0 = rom_addr;
        else          ra1 = rom_addr;
        nrd++;
      end
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".rsp_seen"}, rsp_valid, 1'b1);
    check({tag, ".latency"}, lat, e_lat);
    check({tag, ".rom_reads"}, nrd, e_nrd);
    check({tag, ".rom_addr0"}, ra0, e_ra0);
    check({tag, ".rom_addr1"}, ra1, e_ra1);
    check({tag, ".rdata"}, rsp_rdata, e_rd);
    check({tag, ".fault"}, rsp_fault, e_flt);
    check({tag, ".side_effect"}, rsp_side_effect, e_se);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, ".rsp_drop"}, rsp_valid, 1'b0);
  endtask

  initial begin
    int n;
    logic saw;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.req_ready", req_ready, 1'b1);
    check("rst.rsp_valid", rsp_valid, 1'b0);
    check("rst.rsp_rdata", rsp_rdata, 32'h0);
    check("rst.rsp_fault", rsp_fault, 1'b0);
    check("rst.rom_rd_en", rom_rd_en, 1'b0);
    check("rst.rom_addr", rom_addr, 10'h0);
    check("rst.win_en", win_en, 4'hF);
    check("rst.locked", locked, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //   tag          addr          w     wdata         rdata         flt   se   lat nrd ra0     ra1
    xact("aligned",   32'h0000_1110, 1'b0, 32'h0,       32'h13121110, 1'b0, 1'b0, 4, 1, 10'h110, 10'h000);
    xact("span",      32'h0000_1006, 1'b0, 32'h0,       32'h09080706, 1'b0, 1'b0, 7, 2, 10'h004, 10'h008);
    xact("span_end",  32'h0000_13FB, 1'b0, 32'h0,       32'hFEFDFCFB, 1'b0, 1'b0, 7, 2, 10'h3F8, 10'h3FC);
    xact("overrun",   32'h0000_10FE, 1'b0, 32'h0,       32'h0,        1'b1, 1'b0, 1, 0, 10'h000, 10'h000);
    xact("below",     32'h0000_0FFC, 1'b0, 32'h0,       32'h0,        1'b1, 1'b0, 1, 0, 10'h000, 10'h000);
    xact("above",     32'h0000_1404, 1'b0, 32'h0,       32'h0,        1'b1, 1'b0, 1, 0, 10'h000, 10'h000);
    xact("ctrl_unal", 32'h0000_1401, 1'b0, 32'h0,       32'h0,        1'b1, 1'b0, 1, 0, 10'h000, 10'h000);
    xact("win_write", 32'h0000_1000, 1'b1, 32'h1234,    32'h0,        1'b1, 1'b0, 1, 0, 10'h000, 10'h000);
    xact("ctrl_wr_d", 32'h0000_1400, 1'b1, 32'h0000000D, 32'h0,       1'b0, 1'b1, 1, 0, 10'h000, 10'h000);
    check("win_en_d", win_en, 4'hD);
    xact("win1_off",  32'h0000_1100, 1'b0, 32'h0,       32'h0,        1'b1, 1'b0, 1, 0, 10'h000, 10'h000);
    xact("win2_on",   32'h0000_1208, 1'b0, 32'h0,       32'h0B0A0908, 1'b0, 1'b0, 4, 1, 10'h208, 10'h000);
    xact("ctrl_rd_d", 32'h0000_1400, 1'b0, 32'h0,       32'h0000000D, 1'b0, 1'b0, 1, 0, 10'h000, 10'h000);
    xact("ctrl_lock", 32'h0000_1400, 1'b1, 32'h8000000F, 32'h0,       1'b0, 1'b1, 1, 0, 10'h000, 10'h000);
    xact("lock_wr",   32'h0000_1400, 1'b1, 32'h00000001, 32'h0,       1'b1, 1'b0, 1, 0, 10'h000, 10'h000);
    check("locked_set", locked, 1'b1);
    check("win_en_kept", win_en, 4'hF);
    xact("ctrl_rd_l", 32'h0000_1400, 1'b0, 32'h0,       32'h8000000F, 1'b0, 1'b0, 1, 0, 10'h000, 10'h000);

    // Back-pressure: response must hold while rsp_ready stays low.
    req_addr = 32'h0000_1104; req_write = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold.rsp_valid", rsp_valid, 1'b1);
      check("hold.rdata", rsp_rdata, 32'h07060504);
      check("hold.fault", rsp_fault, 1'b0);
      check("hold.req_ready", req_ready, 1'b0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("hold.release", rsp_valid, 1'b0);
    check("hold.req_ready_back", req_ready, 1'b1);

    // Reset while the first fetch is in flight.
    req_addr = 32'h0000_1008; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort.rd_en", rom_rd_en, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort.rsp_valid", rsp_valid, 1'b0);
    check("abort.req_ready", req_ready, 1'b1);
    check("abort.locked", locked, 1'b0);
    check("abort.win_en", win_en, 4'hF);
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) saw = 1'b1;
      @(posedge clk); #1;
    end
    check("abort.no_stale_rsp", saw, 1'b0);
    xact("after_rst", 32'h0000_1010, 1'b0, 32'h0,      32'h13121110, 1'b0, 1'b0, 4, 1, 10'h010, 10'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
